// File: rtl/hex_display_scanner_pkg.sv
// Shared constants for the hex display scanner: segment patterns, digit count,
// scan FSM encoding and the leading-zero helper.
package hex_display_scanner_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Active-high patterns, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  // Bit i set when nibble i and every nibble above it are zero (digit 0 never).
  function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(input logic [15:0] v);
    leading_zero_mask    = '0;
    leading_zero_mask[3] = (v[15:12] == 4'h0);
    leading_zero_mask[2] = (v[15:8] == 8'h00);
    leading_zero_mask[1] = (v[15:4] == 12'h000);
  endfunction

endpackage

// File: rtl/hex_display_scanner_hex_to_seven_seg.sv
// hex_to_seven_seg: combinational nibble to active-high 7-segment pattern.
// Shared by the display blocks that need a hex glyph.
module hex_to_seven_seg
  import hex_display_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = 7'b0000000;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed hex display driver with per-slot blanking dead-time.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int SLOT_CYCLES    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  digit_enable,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  anode,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        frame_done,
  output state_t      state_dbg
);

  localparam logic [29:0] SLOT_LAST = 30'(SLOT_CYCLES - 1);
  localparam logic [29:0] BLANK_LEN = 30'(BLANK_CYCLES);
  localparam logic [3:0]  AN_OFF    = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]  SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic        DP_OFF    = SEG_ACTIVE_LOW;

  logic [29:0] cnt;
  logic [1:0]  digit;
  state_t      state;
  logic [15:0] sh_value;
  logic [3:0]  sh_en;
  logic [3:0]  sh_dp;
  logic        first_cycle;

  logic        slot_end;
  logic        frame_start;
  logic [29:0] cnt_nxt;
  logic [1:0]  digit_nxt;
  logic [15:0] val_nxt;
  logic [3:0]  en_nxt;
  logic [3:0]  dp_nxt;
  logic [3:0]  lz_mask;
  logic [3:0]  nibble_nxt;
  logic [6:0]  pat_nxt;
  state_t      state_nxt;
  logic [3:0]  anode_on;
  logic [3:0]  digit_sel;

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_mask = leading_zero_mask(value);
`else
  assign lz_mask = 4'h0;
`endif

  // The cycle right after reset behaves like a frame boundary into digit 0.
  always_comb begin
    slot_end    = (cnt == SLOT_LAST);
    frame_start = first_cycle || (slot_end && (digit == 2'd3));
    cnt_nxt     = slot_end ? 30'd0 : cnt + 30'd1;
    digit_nxt   = slot_end ? digit + 2'd1 : digit;
    val_nxt     = frame_start ? value : sh_value;
    en_nxt      = frame_start ? (digit_enable & ~lz_mask) : sh_en;
    dp_nxt      = frame_start ? (dp_mask & ~lz_mask) : sh_dp;
    nibble_nxt  = val_nxt[4*digit_nxt +: 4];
    state_nxt   = (cnt_nxt < BLANK_LEN) ? BLANK : SHOW;
    digit_sel   = 4'b0001 << digit_nxt;
    anode_on    = (state_nxt == SHOW) ? (en_nxt & digit_sel) : 4'h0;
  end

  hex_to_seven_seg u_dec (
    .nibble  (nibble_nxt),
    .pattern (pat_nxt)
  );

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      digit       <= '0;
      state       <= BLANK;
      sh_value    <= '0;
      sh_en       <= '0;
      sh_dp       <= '0;
      first_cycle <= 1'b1;
      anode       <= AN_OFF;
      segments    <= SEG_OFF;
      dp          <= DP_OFF;
      frame_done  <= 1'b0;
    end else begin
      first_cycle <= 1'b0;
      cnt         <= cnt_nxt;
      digit       <= digit_nxt;
      state       <= state_nxt;
      frame_done  <= slot_end && (digit == 2'd3);
      if (frame_start) begin
        sh_value <= val_nxt;
        sh_en    <= en_nxt;
        sh_dp    <= dp_nxt;
      end
      if (first_cycle || slot_end) begin
        segments <= pat_nxt ^ {7{SEG_ACTIVE_LOW}};
        dp       <= dp_nxt[digit_nxt] ^ SEG_ACTIVE_LOW;
      end
      anode <= anode_on ^ {4{AN_ACTIVE_LOW}};
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: 8-cycle slots, one instance with
// 2-cycle dead-time and one with none, frame snapshots and async reset.
module tb_hex_display_scanner;
  import hex_display_scanner_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  digit_enable;
  logic [3:0]  dp_mask;

  logic [3:0] anode, anode_z;
  logic [6:0] segments, segments_z;
  logic       dp, dp_z;
  logic       frame_done, frame_done_z;
  state_t     state_dbg, state_dbg_z;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [5][4];
  logic [3:0] en_tab  [5];
  logic [3:0] dp_tab  [5];

  hex_display_scanner #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) u_dut (
    .qzt_clk(clk), .reset(reset), .value(value), .digit_enable(digit_enable),
    .dp_mask(dp_mask), .anode(anode), .segments(segments), .dp(dp),
    .frame_done(frame_done), .state_dbg(state_dbg)
  );

  hex_display_scanner #(.SLOT_CYCLES(8), .BLANK_CYCLES(0)) u_dut_z (
    .qzt_clk(clk), .reset(reset), .value(value), .digit_enable(digit_enable),
    .dp_mask(dp_mask), .anode(anode_z), .segments(segments_z), .dp(dp_z),
    .frame_done(frame_done_z), .state_dbg(state_dbg_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " anode"}, 32'(anode), 32'hF);
    chk({tag, " seg"}, 32'(segments), 32'h7F);
    chk({tag, " dp"}, 32'(dp), 32'h1);
    chk({tag, " fdone"}, 32'(frame_done), 32'h0);
    chk({tag, " anode_z"}, 32'(anode_z), 32'hF);
  endtask

  initial begin
    int f, d, c;
    logic [3:0] sel_n, exp_an, exp_an_z;
    logic en_b;

    // Active-low glyphs: F=0001110 A=0001000 2=0100100 1=1111001 0=1000000 3=0110000
    seg_tab[0] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    seg_tab[1] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    seg_tab[2] = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    seg_tab[3] = '{7'b1000000, 7'b0110000, 7'b1000000, 7'b1000000};
    seg_tab[4] = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    en_tab = '{4'hF, 4'hF, 4'hF, 4'b0101, 4'hF};
`ifdef LEADING_ZERO_BLANK_EN
    en_tab[3] = 4'b0001;
    en_tab[4] = 4'b0001;
`endif
    dp_tab = '{4'h0, 4'h0, 4'h0, 4'b0001, 4'h0};

    reset        = 1'b1;
    value        = 16'h12AF;
    digit_enable = 4'hF;
    dp_mask      = 4'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_held");
    reset = 1'b0;
    chk_reset_outputs("cycle0");

    for (int cyc = 1; cyc < 160; cyc++) begin
      tick();
      f = cyc / 32;
      d = (cyc / 8) % 4;
      c = cyc % 8;
      en_b     = en_tab[f][d];
      sel_n    = ~(4'b0001 << d);
      exp_an   = (c < 2 || !en_b) ? 4'hF : sel_n;
      exp_an_z = en_b ? sel_n : 4'hF;
      chk($sformatf("c%0d anode", cyc), 32'(anode), 32'(exp_an));
      chk($sformatf("c%0d seg", cyc), 32'(segments), 32'(seg_tab[f][d]));
      chk($sformatf("c%0d dp", cyc), 32'(dp), 32'(!dp_tab[f][d]));
      chk($sformatf("c%0d fdone", cyc), 32'(frame_done), 32'(c == 0 && d == 0));
      chk($sformatf("c%0d state", cyc), 32'(state_dbg), 32'(c >= 2));
      chk($sformatf("c%0d anode_z", cyc), 32'(anode_z), 32'(exp_an_z));
      chk($sformatf("c%0d seg_z", cyc), 32'(segments_z), 32'(seg_tab[f][d]));
      chk($sformatf("c%0d fdone_z", cyc), 32'(frame_done_z), 32'(c == 0 && d == 0));
      if (cyc == 42) value = 16'h0000;
      if (cyc == 70) begin
        value        = 16'h0030;
        digit_enable = 4'b0101;
        dp_mask      = 4'b0001;
      end
      if (cyc == 100) begin
        value        = 16'h0000;
        digit_enable = 4'hF;
        dp_mask      = 4'h0;
      end
    end

    // Cycle 159 is in SHOW; assert reset between edges and look immediately.
    #2 reset = 1'b1;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post_reset c1 anode", 32'(anode), 32'hF);
    chk("post_reset c1 state", 32'(state_dbg), 32'(BLANK));
    chk("post_reset c1 seg", 32'(segments), 32'h40);
    chk("post_reset c1 anode_z", 32'(anode_z), 32'hE);
    tick();
    chk("post_reset c2 anode", 32'(anode), 32'hE);
    chk("post_reset c2 state", 32'(state_dbg), 32'(SHOW));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Downstream consumer of the 16-bit hold latch. Shows its 16-bit word as four hex digits on a multiplexed, common-anode 7-segment display.
- Time-multiplexes digits 0..3 (digit 0 = bits [3:0]), with a blanking dead-time per slot to suppress ghosting.
- Snapshots the input word once per frame so a single frame never mixes old and new nibbles.
- Sits between the hold latch and the board display pins, clocked from the quartz clock.

Parameters:
- SLOT_CYCLES, 50000, qzt_clk cycles per digit slot; legal range 2..2^30-1.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes inactive; must be < SLOT_CYCLES; 0 means no dead-time.
- SEG_ACTIVE_LOW, 1, when 1, segments and dp are driven low to light.
- AN_ACTIVE_LOW, 1, when 1, anodes are driven low to enable.

Ports:
- qzt_clk  input  1  system quartz clock.
- reset  input  1  asynchronous, active-high reset.
- value  input  16  word to display; sampled only at frame start.
- digit_enable  input  4  per-digit enable; sampled with value.
- dp_mask  input  4  per-digit decimal point; sampled with value.
- anode  output  4  digit select; anode[i] drives digit i.
- segments  output  7  {g,f,e,d,c,b,a}; bit 0 = a.
- dp  output  1  decimal point of the current digit.
- frame_done  output  1  one-cycle pulse when digit 3's slot ends.

Behaviour:
- Reset (asynchronous, effective immediately, also mid-frame):
  - anode all inactive; segments and dp off; frame_done=0.
  - slot counter=0, digit index=0, state=BLANK.
  - Shadow registers (value, digit_enable, dp_mask) cleared to 0.
- Slot counter runs 0..SLOT_CYCLES-1 and wraps; it is 30 bits wide.
- FSM has two states:
  - BLANK: counter < BLANK_CYCLES. Anodes inactive. Segments already hold the current digit's pattern.
  - SHOW: counter >= BLANK_CYCLES. Only anode[digit] is active, and only if shadow digit_enable[digit]=1.
- The first cycle out of reset counts as counter=0 of digit 0 with a frame-start capture.
- At counter==SLOT_CYCLES-1, on the next edge:
  - The digit index advances 3→0 wrap.
  - The counter returns to 0.
  - The segments/dp registers load the pattern for the new digit.
- Frame boundary (leaving digit 3):
  - On the same edge, value, digit_enable and dp_mask are captured into the shadows.
  - The pattern loaded for the new digit 0 uses the newly captured value.
  - frame_done is high for exactly that one cycle.
- Outputs are fully registered, with no combinational path from inputs to pins.
  - An input change appears at the pins no earlier than the first cycle of the next frame.
  - Latency from a value change to the pins is at most 4*SLOT_CYCLES+1 cycles.
- A disabled digit still consumes its full slot; its anode stays inactive for the whole slot, so brightness stays uniform.
- Hex decode, active-high, before polarity inversion:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Polarity inversion by SEG_ACTIVE_LOW / AN_ACTIVE_LOW is applied at the output registers only.
- BLANK_CYCLES=0: the FSM never enters BLANK, and the anode switches on the same edge as the segments.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i (i=3..1) is treated as disabled for the frame when its shadow nibble and all higher nibbles are zero.
  - Digit 0 is never suppressed.
  - Suppression is computed at frame capture; a suppressed digit's dp is also off.
- Undefined: every enabled digit is shown, including leading zeros.

Decomposition:
- Shared package/header holds:
  - the 16 segment pattern constants;
  - NUM_DIGITS=4;
  - state encodings BLANK=1'b0, SHOW=1'b1.
- One sub-module: hex_to_seven_seg, a combinational 4-bit nibble → 7-bit active-high pattern decoder. It is reused by other display blocks.

Test Plan:
- Reset mid-SHOW; check immediate response → anode=4'b1111, segments=7'b1111111, dp=1 (active-low defaults) before any clock edge. After release, the digit 0 slot starts at counter 0.
- SLOT_CYCLES=8, BLANK_CYCLES=2, value=16'h12AF, enable=4'hF → per slot, anodes are inactive 2 cycles then active 6.
  - Digits in order show F(0001110), A(0001000), 2(0100100), 1(1111001) (active-low).
  - frame_done pulses every 32 cycles.
- Change value from 16'h12AF to 16'h0000 while digit 1 is showing → the remaining slots of the frame still show 12AF. The next frame shows 0 on all digits.
- digit_enable=4'b0101, dp_mask=4'b0001 → anode[1] and anode[3] are never active. Digit 0 shows dp=0 (lit) during SHOW; all slots keep 8-cycle length.
- With LEADING_ZERO_BLANK_EN, value=16'h0030:
  - digits 3 and 2 are dark;
  - digit 1 shows 3;
  - digit 0 shows 0;
  - value=16'h0000 shows only digit 0.
- BLANK_CYCLES=0 → the anode is never all-inactive after reset, and the one-hot active anode rotates every 8 cycles.
